// File: rtl/cache_assoc_ctrl.sv
// Set-associative cache tag/state controller: tracks tags, valid, dirty and age bits
// per line and reports hit/miss, victim way and dirty write-backs for one request at a time.
module cache_assoc_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int CACHESIZE = 1024,
  parameter int BLOCKSIZE = 16,
  parameter int ASSOC     = 4,
  parameter int COUNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     replace_policy,
  input  logic                     write_policy,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_write,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [$clog2(ASSOC)-1:0] resp_way,
  output logic                     resp_wb,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [COUNT_W-1:0]       num_reads,
  output logic [COUNT_W-1:0]       num_writes,
  output logic [COUNT_W-1:0]       num_read_misses,
  output logic [COUNT_W-1:0]       num_write_misses,
  output logic [COUNT_W-1:0]       num_writebacks
);

  localparam int NUMSETS = (CACHESIZE / (BLOCKSIZE * ASSOC) > 0) ? CACHESIZE / (BLOCKSIZE * ASSOC) : 1;
  localparam int OFF_W   = $clog2(BLOCKSIZE);
  localparam int IDX_W   = $clog2(NUMSETS);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W  = ADDR_W - OFF_W;
  localparam int WAY_W   = $clog2(ASSOC);
  localparam int SET_W   = (IDX_W > 0) ? IDX_W : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0] tag_mem   [NUMSETS][ASSOC];
  logic             valid_mem [NUMSETS][ASSOC];
  logic             dirty_mem [NUMSETS][ASSOC];
  logic [WAY_W-1:0] age_mem   [NUMSETS][ASSOC];

  logic [LINE_W-1:0] line_q;
  logic              write_q, lru_q, wt_q;
  logic              hit_q, vvalid_q, vdirty_q;
  logic [WAY_W-1:0]  way_q, age_q;
  logic [TAG_W-1:0]  vtag_q;

  logic [TAG_W-1:0]  tag;
  logic [SET_W-1:0]  idx;
  logic              unused_offset;

  assign tag           = line_q[LINE_W-1 -: TAG_W];
  assign unused_offset = ^req_addr[OFF_W-1:0];

  generate
    if (IDX_W > 0) begin : g_idx
      assign idx = line_q[SET_W-1:0];
    end else begin : g_no_idx
      assign idx = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = LOOKUP;
      end
      LOOKUP:  next_state = UPDATE;
      UPDATE:  next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Tag match and victim choice: first empty way, otherwise the oldest (age ASSOC-1).
  logic             lk_hit, lk_free;
  logic [WAY_W-1:0] lk_hit_way, lk_victim, lk_cnt;

  always_comb begin
    lk_hit     = 1'b0;
    lk_free    = 1'b0;
    lk_hit_way = '0;
    lk_victim  = '0;
    lk_cnt     = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (!valid_mem[idx][w] && !lk_free) begin
        lk_free   = 1'b1;
        lk_victim = WAY_W'(w);
      end
      if (valid_mem[idx][w]) lk_cnt = lk_cnt + 1'b1;
    end
    if (!lk_free) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (age_mem[idx][w] == WAY_W'(ASSOC - 1)) lk_victim = WAY_W'(w);
      end
    end
  end

  logic              alloc, touch, do_wb;
  logic [LINE_W-1:0] wb_line;

  always_comb begin
    alloc   = !hit_q && !(write_q && wt_q);
    touch   = alloc || (hit_q && lru_q);
    do_wb   = alloc && vvalid_q && vdirty_q;
    wb_line = (LINE_W'(vtag_q) << IDX_W) | LINE_W'(idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NUMSETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          valid_mem[s][w] <= 1'b0;
          dirty_mem[s][w] <= 1'b0;
          age_mem[s][w]   <= '0;
        end
      end
      line_q           <= '0;
      write_q          <= 1'b0;
      lru_q            <= 1'b0;
      wt_q             <= 1'b0;
      hit_q            <= 1'b0;
      vvalid_q         <= 1'b0;
      vdirty_q         <= 1'b0;
      way_q            <= '0;
      age_q            <= '0;
      vtag_q           <= '0;
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      resp_wb          <= 1'b0;
      wb_addr          <= '0;
      num_reads        <= '0;
      num_writes       <= '0;
      num_read_misses  <= '0;
      num_write_misses <= '0;
      num_writebacks   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_q  <= req_addr[ADDR_W-1:OFF_W];
            write_q <= req_write;
            lru_q   <= replace_policy;
            wt_q    <= write_policy;
          end
        end
        LOOKUP: begin
          hit_q    <= lk_hit;
          way_q    <= lk_hit ? lk_hit_way : lk_victim;
          vvalid_q <= valid_mem[idx][lk_victim];
          vdirty_q <= dirty_mem[idx][lk_victim];
          vtag_q   <= tag_mem[idx][lk_victim];
          if (lk_hit)                          age_q <= age_mem[idx][lk_hit_way];
          else if (valid_mem[idx][lk_victim])  age_q <= age_mem[idx][lk_victim];
          else                                 age_q <= lk_cnt;
        end
        UPDATE: begin
          if (alloc) begin
            tag_mem[idx][way_q]   <= tag;
            valid_mem[idx][way_q] <= 1'b1;
            dirty_mem[idx][way_q] <= write_q;
          end
          if (hit_q && write_q && !wt_q) dirty_mem[idx][way_q] <= 1'b1;
          // Younger lines than the touched one slide back by one; the touched line becomes newest.
          if (touch) begin
            for (int w = 0; w < ASSOC; w++) begin
              if (valid_mem[idx][w] && age_mem[idx][w] < age_q)
                age_mem[idx][w] <= age_mem[idx][w] + 1'b1;
            end
            age_mem[idx][way_q] <= '0;
          end
          resp_hit <= hit_q;
          resp_way <= (alloc || hit_q) ? way_q : '0;
          resp_wb  <= do_wb;
          wb_addr  <= do_wb ? {wb_line, {OFF_W{1'b0}}} : '0;
          if (!write_q && num_reads != '1) num_reads <= num_reads + 1'b1;
          if (write_q && num_writes != '1) num_writes <= num_writes + 1'b1;
          if (!hit_q && !write_q && num_read_misses != '1) num_read_misses <= num_read_misses + 1'b1;
          if (!hit_q && write_q && num_write_misses != '1) num_write_misses <= num_write_misses + 1'b1;
          if (do_wb && num_writebacks != '1) num_writebacks <= num_writebacks + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
